// File: rtl/up3x_pkg.sv
// up3x shared definitions: opcode encodings, FSM states, field widths.
package up3x_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OP_W-1:0] OP_STORE = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_JUMP  = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OP_W-1:0] OP_AND   = 4'h5;
    localparam logic [OP_W-1:0] OP_OR    = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR   = 4'h7;
    localparam logic [OP_W-1:0] OP_LOADI = 4'h8;
    localparam logic [OP_W-1:0] OP_JZ    = 4'h9;
    localparam logic [OP_W-1:0] OP_JNEG  = 4'hA;
    localparam logic [OP_W-1:0] OP_JC    = 4'hB;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_MEMRD,
        S_HALT
    } state_t;

    // Opcodes that read a memory operand and finish in MEMRD.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/up3x_if.sv
// Single-port synchronous RAM bus between the up3x core and its memory.
interface up3x_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) ();

    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [DW-1:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/up3x_alu.sv
// up3x accumulator ALU: next acc / carry for memory-operand instructions.
module up3x_alu
    import up3x_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic [OP_W-1:0] op,
    input  logic [DW-1:0]   acc,
    input  logic [DW-1:0]   rdata,
    input  logic            cy,
    output logic [DW-1:0]   acc_nxt_c,
    output logic            cy_nxt_c
);

    logic [DW:0] sum;

    // One extra bit on add/sub gives carry out and unsigned borrow.
    always_comb begin
        acc_nxt_c = acc;
        cy_nxt_c  = cy;
        sum       = '0;
        case (op)
            OP_ADD: begin
                sum       = {1'b0, acc} + {1'b0, rdata};
                acc_nxt_c = sum[DW-1:0];
                cy_nxt_c  = sum[DW];
            end
            OP_SUB: begin
                sum       = {1'b0, acc} - {1'b0, rdata};
                acc_nxt_c = sum[DW-1:0];
                cy_nxt_c  = sum[DW];
            end
            OP_LOAD: acc_nxt_c = rdata;
            OP_AND:  acc_nxt_c = acc & rdata;
            OP_OR:   acc_nxt_c = acc | rdata;
            OP_XOR:  acc_nxt_c = acc ^ rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/up3x.sv
// up3x accumulator processor core: FETCH/LATCH/EXEC/MEMRD/HALT sequencer.
module up3x
    import up3x_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          resume,
    up3x_if.master        mem,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] ir,
    output logic          cy,
    output logic          halted
);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   pc_nxt;
    logic [DW-1:0]   acc_nxt;
    logic [DW-1:0]   ir_nxt;
    logic            cy_nxt;
    logic [OP_W-1:0] op;
    logic [AW-1:0]   operand;
    logic [DW-1:0]   alu_acc;
    logic            alu_cy;

    assign op        = ir[DW-1 -: OP_W];
    assign operand   = ir[AW-1:0];
    assign mem.wdata = acc;
    assign halted    = (state == S_HALT);

    up3x_alu #(.DW(DW)) u_alu (
        .op        (op),
        .acc       (acc),
        .rdata     (mem.rdata),
        .cy        (cy),
        .acc_nxt_c (alu_acc),
        .cy_nxt_c  (alu_cy)
    );

    // State and architectural registers; async reset also kills a pending store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= AW'(RESET_PC);
            acc   <= '0;
            ir    <= '0;
            cy    <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            acc   <= acc_nxt;
            ir    <= ir_nxt;
            cy    <= cy_nxt;
        end
    end

    // Next-state, register updates and memory address/write-enable mux.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        acc_nxt   = acc;
        ir_nxt    = ir;
        cy_nxt    = cy;
        mem.addr  = pc;
        mem.we    = 1'b0;
        case (state)
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: begin
                ir_nxt    = mem.rdata;
                pc_nxt    = pc + AW'(1);
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                if (is_mem_op(op)) begin
                    mem.addr  = operand;
                    state_nxt = S_MEMRD;
                end else begin
                    case (op)
                        OP_STORE: begin
                            mem.addr = operand;
                            mem.we   = 1'b1;
                        end
                        OP_LOADI: acc_nxt = DW'(operand);
                        OP_JUMP:  pc_nxt  = operand;
                        OP_JZ:    if (acc == '0) pc_nxt = operand;
                        OP_JNEG:  if (acc[DW-1]) pc_nxt = operand;
                        OP_JC:    if (cy) pc_nxt = operand;
                        OP_HALT:  state_nxt = S_HALT;
                        default:  ;
                    endcase
                end
            end
            S_MEMRD: begin
                acc_nxt   = alu_acc;
                cy_nxt    = alu_cy;
                state_nxt = S_FETCH;
            end
            S_HALT: if (resume) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: doc/up3x.md
# up3x

Parametrised accumulator processor, the successor to the 8-bit-address uP3 core in the de2-115 designs. Executes a single-accumulator instruction set from an external synchronous single-port RAM. Adds subtract/logic operations, an immediate load, conditional branches, a carry flag, and halt/resume control. Data width, address width and reset vector are parameters. Sits between the board top level (clock, reset, debug LEDs/7-seg of `pc`/`acc`) and an on-chip RAM instance.

## Interface
- `DW`, 16, data/instruction width; must satisfy `DW >= AW + 4`
- `AW`, 8, memory address width; program counter width
- `RESET_PC`, 0, value loaded into `pc` on reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `resume`  in  1  leave HALT; ignored in every other state
- `mem_rdata`  in  DW  RAM read data; valid one cycle after `mem_addr` is presented
- `mem_addr`  out  AW  RAM address; combinational from state, `pc`, `ir`
- `mem_wdata`  out  DW  always equals `acc`
- `mem_we`  out  1  write enable; combinational, high only in EXEC of STORE
- `pc`  out  AW  program counter
- `acc`  out  DW  accumulator
- `ir`  out  DW  instruction register
- `cy`  out  1  carry/borrow flag
- `halted`  out  1  high while in HALT

## Operation
- Instruction: `op = ir[DW-1:DW-4]`, `operand = ir[AW-1:0]`; bits between are ignored.
- Opcodes: 0 ADD, 1 STORE, 2 LOAD, 3 JUMP (encodings kept from uP3), 4 SUB, 5 AND, 6 OR, 7 XOR, 8 LOADI, 9 JZ, A JNEG, B JC, C–E NOP, F HALT.
- States: FETCH, LATCH, EXEC, MEMRD, HALT.
  - FETCH: `mem_addr=pc`, go LATCH.
  - LATCH: `ir<=mem_rdata`, `pc<=pc+1` (mod 2^AW), go EXEC.
  - EXEC, per opcode:
    - ADD/SUB/LOAD/AND/OR/XOR: `mem_addr=operand`, go MEMRD.
    - STORE: `mem_addr=operand`, `mem_we=1`, go FETCH.
    - LOADI: `acc<=zero-extended operand`, go FETCH.
    - JUMP: `pc<=operand`, go FETCH.
    - JZ: if `acc==0`, `pc<=operand`; go FETCH.
    - JNEG: if `acc[DW-1]`, `pc<=operand`; go FETCH.
    - JC: if `cy`, `pc<=operand`; go FETCH.
    - NOP: go FETCH.
    - HALT: go HALT.
  - MEMRD: `mem_addr=pc`. Apply `mem_rdata` to `acc` per opcode, go FETCH.
    - ADD: `{cy,acc}<=acc+rdata`, DW+1-bit sum.
    - SUB: `acc<=acc-rdata`; `cy<=1` on borrow (`acc<rdata` unsigned).
    - AND/OR/XOR/LOAD: update `acc` only; `cy` unchanged.
  - HALT: `mem_addr=pc`, `halted=1`. `resume` high at a clock edge → FETCH from current `pc` (the address after the HALT instruction).
- `mem_addr` is `pc` in every state/opcode not listed above.
- Arithmetic wraps mod 2^DW. `pc` wraps from 2^AW-1 to 0 with no flag.
- Reset values: state FETCH, `pc=RESET_PC`, `acc=0`, `ir=0`, `cy=0`, `halted=0`, `mem_we=0`.
- Reset asserted mid-instruction (including EXEC of STORE): `mem_we` drops immediately with `rst_n` (asynchronous); no partial register update survives.

## Timing
- Cycles per instruction:
  - Memory-operand ALU ops and LOAD: 4 (FETCH, LATCH, EXEC, MEMRD).
  - STORE, LOADI, jumps, NOP: 3.
  - HALT: 3 to reach HALT state.
- First FETCH is the first rising edge after `rst_n` deasserts; `mem_addr=RESET_PC` is already driven during reset.
- `resume` is sampled only in HALT; a 1-cycle pulse suffices. FETCH occurs the cycle after the sampling edge.
- STORE to the address of the next instruction is visible to the following FETCH, since the write completes at the EXEC edge.

## Structure
- Package `up3x_pkg`: opcode constants (4-bit), state enum, opcode field width (4).
- One sub-module `up3x_alu`: combinational; inputs `op`, `acc`, `rdata`, `cy`; outputs next `acc`, next `cy`.
- The core holds the state machine, `pc`, `ir`, `acc`, `cy` and the address mux.
- Bench uses a behavioural RAM with 1-cycle read latency and write-first behaviour.

## Test plan
- Reset, `RESET_PC=0`; RAM[0]=LOADI 5, RAM[1]=ADD 0x10, RAM[0x10]=7, RAM[2]=HALT → `acc=12`, `cy=0`, `halted=1` at cycle 10, `pc=3`.
- `acc=0xFFFF`, ADD of 1 → `acc=0`, `cy=1`; next JC 0x20 → `pc=0x20`. SUB 1 from 0 → `acc=0xFFFF`, `cy=1`; JNEG taken.
- STORE 0x30 with `acc=0xBEEF` → exactly one cycle `mem_we=1`, `mem_addr=0x30`, `mem_wdata=0xBEEF`; LOAD 0x30 returns 0xBEEF.
- JZ with `acc=1` → not taken, `pc` = JZ address + 1. Instruction at 0xFF (AW=8) that is not a jump → next FETCH at 0x00.
- In HALT, hold `resume=0` for 20 cycles → `pc`/`acc` unchanged. Pulse `resume` → FETCH at the next edge; `halted=0`.
- Assert `rst_n` low during EXEC of STORE → `mem_we` drops the same cycle, RAM unmodified, `pc=RESET_PC`, `acc=0`. Repeat at DW=24, AW=10.
